// File: rtl/dsm_pkg.sv
// Shared types and helpers for the time-multiplexed delta-sigma modulator.
package dsm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        UPDATE = 2'd2,
        FRAME  = 2'd3
    } dsm_state_e;

    // Feedback level for a W-bit full scale: +max when the last bit was 1, -max otherwise.
    function automatic logic signed [63:0] dsm_fb(input int unsigned w, input logic q);
        logic signed [63:0] half;
        half = 64'sd1 <<< (w - 1);
        return q ? (half - 64'sd1) : -half;
    endfunction

endpackage

// File: rtl/dsm_step.sv
// One second-order delta-sigma modulator step; purely combinational, wraps modulo 2^(2W).
module dsm_step
    import dsm_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W-1:0]   din_q,
    input  logic signed [2*W-1:0] inte0,
    input  logic signed [2*W-1:0] inte1,
    input  logic                  q,
    output logic signed [2*W-1:0] inte0_nxt,
    output logic signed [2*W-1:0] inte1_nxt,
    output logic                  q_nxt
);

    logic signed [2*W-1:0] fb;
    logic signed [2*W-1:0] din_ext;
    logic signed [2*W-1:0] rd0;
    logic signed [2*W-1:0] rd1;

    always_comb begin
        fb      = (2*W)'(dsm_fb(W, q));
        din_ext = (2*W)'(din_q);
        rd0     = din_ext - fb + inte0;
        rd1     = rd0 - fb + inte1;
    end

    assign inte0_nxt = rd0;
    assign inte1_nxt = rd1;
    // Strictly positive: sign bit clear and not zero.
    assign q_nxt     = ~rd1[2*W-1] & (|rd1);

endmodule

// File: rtl/dsm_channel_scheduler.sv
// Round-robin scheduler sharing one dsm_step across CH channels with per-channel state.
module dsm_channel_scheduler
    import dsm_pkg::*;
#(
    parameter  int W  = 16,
    parameter  int CH = 4,
    localparam int PW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [CH-1:0]   ch_mask,
    input  logic [CH*W-1:0] din,
    output logic [CH-1:0]   pdm,
    output logic            pdm_vld,
    output logic [PW-1:0]   pdm_ch,
    output logic            frame_tick,
    output logic            busy
);

    dsm_state_e            state;
    logic [PW-1:0]         ptr;
    logic [CH-1:0]         act_mask;
    logic signed [W-1:0]   din_q;
    logic signed [2*W-1:0] inte0 [CH];
    logic signed [2*W-1:0] inte1 [CH];
    logic [CH-1:0]         q_st;

    logic signed [2*W-1:0] inte0_nxt;
    logic signed [2*W-1:0] inte1_nxt;
    logic                  q_nxt;
    logic                  last_ch;

    assign last_ch = (ptr == PW'(CH - 1));

    dsm_step #(.W(W)) u_step (
        .din_q     (din_q),
        .inte0     (inte0[ptr]),
        .inte1     (inte1[ptr]),
        .q         (q_st[ptr]),
        .inte0_nxt (inte0_nxt),
        .inte1_nxt (inte1_nxt),
        .q_nxt     (q_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            act_mask   <= '0;
            din_q      <= '0;
            q_st       <= '0;
            pdm_vld    <= 1'b0;
            pdm_ch     <= '0;
            frame_tick <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                inte0[k] <= '0;
                inte1[k] <= '0;
            end
        end else begin
            pdm_vld    <= 1'b0;
            frame_tick <= 1'b0;
            unique case (state)
                IDLE: begin
                    ptr <= '0;
                    if (run) begin
                        act_mask <= ch_mask;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    din_q <= din[ptr*W +: W];
                    if (act_mask[ptr]) begin
                        state <= UPDATE;
                    end else if (last_ch) begin
                        state <= FRAME;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                // Write-back of the shared step into the serviced channel's slot.
                UPDATE: begin
                    inte0[ptr] <= inte0_nxt;
                    inte1[ptr] <= inte1_nxt;
                    q_st[ptr]  <= q_nxt;
                    pdm_vld    <= 1'b1;
                    pdm_ch     <= ptr;
                    if (last_ch) begin
                        state <= FRAME;
                    end else begin
                        ptr   <= ptr + 1'b1;
                        state <= SCAN;
                    end
                end
                FRAME: begin
                    frame_tick <= 1'b1;
                    ptr        <= '0;
                    // Channels disabled by the incoming mask restart from a clean state.
                    for (int k = 0; k < CH; k++) begin
                        if (!ch_mask[k]) begin
                            inte0[k] <= '0;
                            inte1[k] <= '0;
                            q_st[k]  <= 1'b0;
                        end
                    end
                    if (run) begin
                        act_mask <= ch_mask;
                        state    <= SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pdm  = q_st;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dsm_channel_scheduler.sv
// Scoreboard bench: a frame-level reference model predicts updates and ticks, a monitor checks them.
module tb_dsm_channel_scheduler;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int PW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            run;
    logic [CH-1:0]   ch_mask;
    logic [CH*W-1:0] din;
    logic [CH-1:0]   pdm;
    logic            pdm_vld;
    logic [PW-1:0]   pdm_ch;
    logic            frame_tick;
    logic            busy;

    dsm_channel_scheduler #(.W(W), .CH(CH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ch_mask    (ch_mask),
        .din        (din),
        .pdm        (pdm),
        .pdm_vld    (pdm_vld),
        .pdm_ch     (pdm_ch),
        .frame_tick (frame_tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void chk_rng(string name, longint act, longint lo, longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int cyc;
        int ch;
        bit q;
    } exp_t;

    exp_t   exp_q[$];
    int     tick_q[$];
    bit     m_q[CH];
    longint m_i0[CH];
    longint m_i1[CH];
    bit     m_busy;
    int     ones[CH];
    int     upd[CH];

    function automatic void mclear();
        for (int k = 0; k < CH; k++) begin
            m_q[k]  = 1'b0;
            m_i0[k] = 0;
            m_i1[k] = 0;
        end
        m_busy = 1'b0;
    endfunction

    function automatic longint wrap(longint v);
        logic signed [2*W-1:0] t;
        t = v[2*W-1:0];
        return longint'(t);
    endfunction

    function automatic void mstep(int k, longint dq);
        longint fb, r0, r1;
        fb = m_q[k] ? ((longint'(1) << (W-1)) - 1) : -(longint'(1) << (W-1));
        r0 = wrap(dq - fb + m_i0[k]);
        r1 = wrap(r0 - fb + m_i1[k]);
        m_i0[k] = r0;
        m_i1[k] = r1;
        m_q[k]  = (r1 > 0);
    endfunction

    task automatic medge(output bit r);
        @(posedge clk);
        r = !rst_n;
        if (r) mclear();
    endtask

    initial begin
        bit r;
        bit going;
        logic [CH-1:0] m;
        longint dq;
        mclear();
        forever begin
            medge(r);
            if (!r && run) begin
                m = ch_mask;
                m_busy = 1'b1;
                going = 1'b1;
                while (going && !r) begin
                    for (int k = 0; k < CH; k++) begin
                        medge(r);
                        if (r) break;
                        dq = longint'($signed(din[k*W +: W]));
                        if (m[k]) begin
                            medge(r);
                            if (r) break;
                            mstep(k, dq);
                            exp_q.push_back(exp_t'{cyc + 1, k, m_q[k]});
                        end
                    end
                    if (!r) begin
                        medge(r);
                        if (!r) begin
                            tick_q.push_back(cyc + 1);
                            for (int k = 0; k < CH; k++) begin
                                if (!ch_mask[k]) begin
                                    m_q[k] = 1'b0; m_i0[k] = 0; m_i1[k] = 0;
                                end
                            end
                            if (run) m = ch_mask;
                            else begin going = 1'b0; m_busy = 1'b0; end
                        end
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        logic [CH-1:0] mv;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL vld_missing: got no pdm_vld, expected ch %0d at cycle %0d", exp_q[0].ch, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (pdm_vld) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    chk("pdm_ch", pdm_ch, e.ch);
                    chk("pdm_bit", pdm[e.ch], e.q);
                    upd[e.ch]++;
                    ones[e.ch] += int'(pdm[e.ch]);
                end else begin
                    chk("pdm_vld_unexpected", pdm_vld, 0);
                end
            end
            while (tick_q.size() > 0 && tick_q[0] < cyc) begin
                checks++; errors++;
                $display("FAIL tick_missing: got no frame_tick, expected at cycle %0d", tick_q[0]);
                void'(tick_q.pop_front());
            end
            if (frame_tick) begin
                if (tick_q.size() > 0 && tick_q[0] == cyc) void'(tick_q.pop_front());
                else chk("frame_tick_unexpected", frame_tick, 0);
            end
            for (int k = 0; k < CH; k++) mv[k] = m_q[k];
            chk("pdm_vec", pdm, mv);
            chk("busy", busy, m_busy);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick_in();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(int ch, int budget, output int fc);
        fc = -1;
        repeat (budget) begin
            @(negedge clk);
            if (pdm_vld && pdm_ch == PW'(ch)) begin fc = cyc; break; end
        end
    endtask

    task automatic wait_tick(int budget, output int fc);
        fc = -1;
        repeat (budget) begin
            @(negedge clk);
            if (frame_tick) begin fc = cyc; break; end
        end
    endtask

    task automatic wait_idle(int budget);
        repeat (budget) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_reached", busy, 0);
    endtask

    initial begin
        int t0, f, f2, s_one0, s_upd0, s_one2, s_upd2, n;
        rst_n = 1'b0; run = 1'b1; ch_mask = 4'b1111; din = {$urandom(), $urandom()};

        // reset held for three cycles with run high
        repeat (3) tick_in();
        rst_n = 1'b1; ch_mask = '0; run = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_pdm", pdm, 0);
            chk("rst_vld", pdm_vld, 0);
            chk("rst_pdm_ch", pdm_ch, 0);
            chk("rst_tick", frame_tick, 0);
            chk("rst_busy", busy, 0);
        end

        // single channel, zero input: latency and 50% density
        tick_in();
        din = '0; ch_mask = 4'b0001;
        tick_in();
        t0 = cyc; run = 1'b1;
        wait_vld(0, 10, f);
        chk("first_vld_seen", f >= 0, 1);
        chk("first_vld_latency", f - t0, 3);
        chk("first_pdm0", pdm[0], 1);
        @(posedge clk);
        s_one0 = ones[0]; s_upd0 = upd[0];
        repeat (8000) begin
            @(posedge clk);
            if (upd[0] - s_upd0 >= 1024) break;
        end
        chk("din0_updates", upd[0] - s_upd0, 1024);
        chk_rng("din0_ones", ones[0] - s_one0, 508, 516);
        run = 1'b0;
        wait_idle(20);

        // mask 1010: frame length 7
        tick_in();
        din = {$urandom(), $urandom()}; ch_mask = 4'b1010; run = 1'b1;
        wait_tick(30, f);
        chk("tick1010_seen", f >= 0, 1);
        repeat (3) begin
            wait_tick(30, f2);
            chk("frame_len_1010", f2 - f, 7);
            f = f2;
        end
        run = 1'b0;
        wait_idle(20);

        // opposite DC levels on ch0 and ch2
        tick_in();
        din = {$urandom(), $urandom()};
        din[0*W +: W] = 16'sd16384;
        din[2*W +: W] = -16'sd16384;
        ch_mask = 4'b0101; run = 1'b1;
        wait_tick(30, f);
        @(posedge clk);
        s_one0 = ones[0]; s_upd0 = upd[0]; s_one2 = ones[2]; s_upd2 = upd[2];
        repeat (16000) begin
            @(posedge clk);
            if (upd[2] - s_upd2 >= 2048) break;
        end
        chk("dc_updates_ch0", upd[0] - s_upd0, 2048);
        chk("dc_updates_ch2", upd[2] - s_upd2, 2048);
        chk_rng("dc_ones_ch0", ones[0] - s_one0, 1516, 1556);
        chk_rng("dc_ones_ch2", ones[2] - s_one2, 492, 532);
        run = 1'b0;
        wait_idle(20);

        // mask change mid-frame 0011 -> 0001
        tick_in();
        din = {$urandom(), $urandom()}; ch_mask = 4'b0011; run = 1'b1;
        wait_vld(0, 20, f);
        ch_mask = 4'b0001;
        wait_vld(1, 6, f);
        chk("ch1_still_updated", f >= 0, 1);
        wait_tick(20, f);
        chk("ch1_cleared_pdm", pdm[1], 0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (pdm_vld && pdm_ch == 2'd1) n++;
            if (frame_tick) break;
        end
        chk("ch1_not_updated", n, 0);

        // drop run mid-frame
        ch_mask = 4'b0011;
        wait_tick(20, f);
        wait_vld(0, 20, f);
        run = 1'b0;
        wait_tick(20, f);
        chk("run_drop_tick_seen", f >= 0, 1);
        @(negedge clk);
        chk("busy_after_tick", busy, 0);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (pdm_vld) n++;
        end
        chk("no_vld_after_stop", n, 0);

        // reset pulse during UPDATE of ch0
        tick_in();
        din = '0; din[0*W +: W] = W'(1000 + $urandom_range(0, 1000)); ch_mask = 4'b0001; run = 1'b1;
        wait_tick(30, f);
        @(posedge clk); #1;
        rst_n = 1'b0; run = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_pdm", pdm, 0);
        chk("midrst_vld", pdm_vld, 0);
        chk("midrst_tick", frame_tick, 0);
        tick_in();
        din = '0;
        tick_in();
        t0 = cyc; run = 1'b1;
        wait_vld(0, 10, f);
        chk("post_rst_latency", f - t0, 3);
        chk("post_rst_pdm0", pdm[0], 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            tick_in();
            din = {$urandom(), $urandom()};
            if ($urandom_range(0, 15) == 0) ch_mask = 4'($urandom_range(0, 15));
            run = ($urandom_range(0, 29) != 0);
        end
        run = 1'b0;
        wait_idle(30);
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size() + tick_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
